// File: rtl/fetch_buffer_super_if.sv
// Fetch/decode side bundle of the superscalar instruction queue.
// The master drives the fetch lanes, flush and out_accept; the buffer is the slave.
interface fetch_buffer_super_if #(
    parameter int size  = 32,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            flush;
    logic            in_valid_0, in_valid_1, in_valid_2, in_valid_3, in_valid_4;
    logic [size-1:0] in_inst_0, in_inst_1, in_inst_2, in_inst_3, in_inst_4;
    logic [size-1:0] in_pc_0, in_pc_1, in_pc_2, in_pc_3, in_pc_4;
    logic            out_valid_0, out_valid_1, out_valid_2;
    logic [size-1:0] out_inst_0, out_inst_1, out_inst_2;
    logic [size-1:0] out_pc_0, out_pc_1, out_pc_2;
    logic [1:0]      out_accept;
    logic            fetch_stall;
    logic [CW-1:0]   occupancy;

    modport master (
        output flush,
        output in_valid_0, in_valid_1, in_valid_2, in_valid_3, in_valid_4,
        output in_inst_0, in_inst_1, in_inst_2, in_inst_3, in_inst_4,
        output in_pc_0, in_pc_1, in_pc_2, in_pc_3, in_pc_4,
        output out_accept,
        input  out_valid_0, out_valid_1, out_valid_2,
        input  out_inst_0, out_inst_1, out_inst_2,
        input  out_pc_0, out_pc_1, out_pc_2,
        input  fetch_stall, occupancy
    );

    modport slave (
        input  flush,
        input  in_valid_0, in_valid_1, in_valid_2, in_valid_3, in_valid_4,
        input  in_inst_0, in_inst_1, in_inst_2, in_inst_3, in_inst_4,
        input  in_pc_0, in_pc_1, in_pc_2, in_pc_3, in_pc_4,
        input  out_accept,
        output out_valid_0, out_valid_1, out_valid_2,
        output out_inst_0, out_inst_1, out_inst_2,
        output out_pc_0, out_pc_1, out_pc_2,
        output fetch_stall, occupancy
    );
endinterface

// File: rtl/fetch_buffer_super.sv
// Instruction queue between fetch and decode: up to 5 pushes and 3 pops per cycle,
// oldest 3 entries presented to decode, single-cycle flush on misprediction.
module fetch_buffer_super #(
    parameter int size  = 32,
    parameter int DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    fetch_buffer_super_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0]   head, tail;
    logic [CW-1:0]   count;
    logic [size-1:0] mem_inst [DEPTH];
    logic [size-1:0] mem_pc   [DEPTH];

    logic [4:0]      lane_valid;
    logic [size-1:0] lane_inst [5];
    logic [size-1:0] lane_pc   [5];
    logic [2:0]      wn_raw, wn;
    logic [1:0]      avail, rn;
    logic            stall;
    logic            slot_valid [3];
    logic [size-1:0] slot_inst  [3];
    logic [size-1:0] slot_pc    [3];

    always_comb begin
        lane_valid   = {bus.in_valid_4, bus.in_valid_3, bus.in_valid_2,
                        bus.in_valid_1, bus.in_valid_0};
        lane_inst[0] = bus.in_inst_0;
        lane_inst[1] = bus.in_inst_1;
        lane_inst[2] = bus.in_inst_2;
        lane_inst[3] = bus.in_inst_3;
        lane_inst[4] = bus.in_inst_4;
        lane_pc[0]   = bus.in_pc_0;
        lane_pc[1]   = bus.in_pc_1;
        lane_pc[2]   = bus.in_pc_2;
        lane_pc[3]   = bus.in_pc_3;
        lane_pc[4]   = bus.in_pc_4;
    end

    // Only the contiguous run of valid lanes starting at lane 0 is taken.
    always_comb begin
        logic run;
        run    = 1'b1;
        wn_raw = 3'd0;
        for (int j = 0; j < 5; j++) begin
            run = run & lane_valid[j];
            if (run) wn_raw = wn_raw + 3'd1;
        end
    end

    assign stall = (count > CW'(DEPTH - 5));
    assign wn    = (stall || bus.flush) ? 3'd0 : wn_raw;
    assign avail = (count >= CW'(3)) ? 2'd3 : count[1:0];
    assign rn    = (bus.out_accept < avail) ? bus.out_accept : avail;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (bus.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(rn);
            tail  <= tail + AW'(wn);
            count <= count + CW'(wn) - CW'(rn);
        end
    end

    // Storage is left untouched by reset and flush; count gates visibility.
    always_ff @(posedge clk) begin
        for (int j = 0; j < 5; j++) begin
            if (3'(j) < wn) begin
                mem_inst[tail + AW'(j)] <= lane_inst[j];
                mem_pc[tail + AW'(j)]   <= lane_pc[j];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            slot_valid[k] = (count > CW'(k));
            slot_inst[k]  = slot_valid[k] ? mem_inst[head + AW'(k)] : '0;
            slot_pc[k]    = slot_valid[k] ? mem_pc[head + AW'(k)]   : '0;
        end
    end

    assign bus.out_valid_0 = slot_valid[0];
    assign bus.out_valid_1 = slot_valid[1];
    assign bus.out_valid_2 = slot_valid[2];
    assign bus.out_inst_0  = slot_inst[0];
    assign bus.out_inst_1  = slot_inst[1];
    assign bus.out_inst_2  = slot_inst[2];
    assign bus.out_pc_0    = slot_pc[0];
    assign bus.out_pc_1    = slot_pc[1];
    assign bus.out_pc_2    = slot_pc[2];
    assign bus.fetch_stall = stall;
    assign bus.occupancy   = count;
endmodule

// File: tb/tb_fetch_buffer_super.sv
// Directed and randomized bench for fetch_buffer_super against a queue-based model.
module tb_fetch_buffer_super;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fetch_buffer_super_if #(.size(32), .DEPTH(DEPTH)) bus ();

    fetch_buffer_super #(.size(32), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] model_q [$];   // {inst, pc}, oldest first
    logic [31:0] pc_next;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [63:0] e [3];
        logic        ev [3];
        for (int k = 0; k < 3; k++) begin
            ev[k] = (model_q.size() > k);
            e[k]  = ev[k] ? model_q[k] : 64'h0;
        end
        check({tag, " occupancy"}, 64'(bus.occupancy), 64'(model_q.size()));
        check({tag, " stall"}, 64'(bus.fetch_stall), 64'((DEPTH - model_q.size()) < 5));
        check({tag, " valid0"}, 64'(bus.out_valid_0), 64'(ev[0]));
        check({tag, " valid1"}, 64'(bus.out_valid_1), 64'(ev[1]));
        check({tag, " valid2"}, 64'(bus.out_valid_2), 64'(ev[2]));
        check({tag, " slot0"}, {bus.out_inst_0, bus.out_pc_0}, e[0]);
        check({tag, " slot1"}, {bus.out_inst_1, bus.out_pc_1}, e[1]);
        check({tag, " slot2"}, {bus.out_inst_2, bus.out_pc_2}, e[2]);
    endtask

    task automatic drive_idle();
        bus.flush = 1'b0;
        bus.out_accept = 2'd0;
        {bus.in_valid_4, bus.in_valid_3, bus.in_valid_2, bus.in_valid_1, bus.in_valid_0} = 5'b0;
    endtask

    // One clock: drive, apply the model's rules, then check after the edge.
    task automatic step(input logic [4:0] v, input logic [1:0] acc, input logic fl,
                        input logic [31:0] base, input string tag, output int wn_o);
        logic [31:0] inst [5];
        int sz, rn, avail;
        bit stalled;
        for (int j = 0; j < 5; j++) inst[j] = $urandom;
        bus.flush = fl;
        bus.out_accept = acc;
        {bus.in_valid_4, bus.in_valid_3, bus.in_valid_2, bus.in_valid_1, bus.in_valid_0} = v;
        bus.in_inst_0 = inst[0]; bus.in_pc_0 = base;
        bus.in_inst_1 = inst[1]; bus.in_pc_1 = base + 32'd4;
        bus.in_inst_2 = inst[2]; bus.in_pc_2 = base + 32'd8;
        bus.in_inst_3 = inst[3]; bus.in_pc_3 = base + 32'd12;
        bus.in_inst_4 = inst[4]; bus.in_pc_4 = base + 32'd16;

        sz = model_q.size();
        stalled = (DEPTH - sz) < 5;
        wn_o = 0;
        if (!stalled && !fl)
            while (wn_o < 5 && v[wn_o]) wn_o++;
        avail = (sz < 3) ? sz : 3;
        rn = (int'(acc) < avail) ? int'(acc) : avail;

        @(posedge clk);
        #1;
        if (fl) begin
            model_q.delete();
        end else begin
            for (int i = 0; i < rn; i++) void'(model_q.pop_front());
            for (int j = 0; j < wn_o; j++) model_q.push_back({inst[j], base + 32'(4 * j)});
        end
        check_outputs(tag);
    endtask

    initial begin
        int w, guard, groups;
        drive_idle();
        bus.in_inst_0 = '0; bus.in_inst_1 = '0; bus.in_inst_2 = '0; bus.in_inst_3 = '0; bus.in_inst_4 = '0;
        bus.in_pc_0 = '0; bus.in_pc_1 = '0; bus.in_pc_2 = '0; bus.in_pc_3 = '0; bus.in_pc_4 = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        step(5'b00000, 2'd3, 1'b0, 32'h0, "idle_overaccept", w);

        step(5'b11111, 2'd0, 1'b0, 32'h0, "first_group", w);
        check("first_group pc0", 64'(bus.out_pc_0), 64'h0);
        check("first_group pc2", 64'(bus.out_pc_2), 64'h8);
        step(5'b00000, 2'd3, 1'b0, 32'h0, "pop3", w);
        check("pop3 pc0", 64'(bus.out_pc_0), 64'hC);
        check("pop3 pc1", 64'(bus.out_pc_1), 64'h10);

        pc_next = 32'h14;
        for (int g = 0; g < 3; g++) begin
            step(5'b11111, 2'd0, 1'b0, pc_next, "fill", w);
            pc_next += 32'(4 * w);
        end
        check("fill stalled", 64'(bus.fetch_stall), 64'h1);
        for (int g = 0; g < 2; g++) begin
            step(5'b11111, 2'd0, 1'b0, pc_next, "hold_stalled", w);
            pc_next += 32'(4 * w);
        end

        guard = 0;
        while (bus.fetch_stall && guard < 20) begin
            step(5'b00000, 2'd3, 1'b0, 32'h0, "drain_stall", w);
            guard++;
        end
        groups = 0;
        guard = 0;
        while (groups < 4 && guard < 40) begin
            step(5'b11111, 2'd3, 1'b0, pc_next, "wrap_stream", w);
            pc_next += 32'(4 * w);
            if (w == 5) groups++;
            guard++;
        end
        check("wrap_stream groups", 64'(groups), 64'd4);

        guard = 0;
        while (model_q.size() != 0 && guard < 20) begin
            step(5'b00000, 2'd3, 1'b0, 32'h0, "drain", w);
            guard++;
        end
        step(5'b11011, 2'd0, 1'b0, 32'h200, "partial_lanes", w);
        check("partial_lanes count", 64'(bus.occupancy), 64'd2);
        check("partial_lanes pc1", 64'(bus.out_pc_1), 64'h204);

        step(5'b11111, 2'd0, 1'b0, 32'h300, "to_seven", w);
        step(5'b11111, 2'd2, 1'b1, 32'h400, "flush", w);
        check("flush empty", 64'(bus.occupancy), 64'd0);
        step(5'b00001, 2'd0, 1'b0, 32'h100, "after_flush", w);
        check("after_flush pc0", 64'(bus.out_pc_0), 64'h100);

        pc_next = 32'h1000;
        for (int c = 0; c < 400; c++) begin
            logic [4:0] v;
            v = 5'($urandom);
            if ($urandom_range(0, 2) == 0) v = 5'b11111;
            step(v, 2'($urandom), ($urandom_range(0, 29) == 0), pc_next, "random", w);
            pc_next += 32'(4 * w);
        end

        step(5'b11111, 2'd0, 1'b0, pc_next, "pre_reset", w);
        drive_idle();
        #3;
        reset = 1'b0;
        #1;
        model_q.delete();
        check("async_reset occupancy", 64'(bus.occupancy), 64'd0);
        check("async_reset valid0", 64'(bus.out_valid_0), 64'd0);
        check_outputs("async_reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        step(5'b00111, 2'd1, 1'b0, 32'h500, "post_reset", w);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
